bg_sram_reader: RTL

- Responder side of the background pixel-address interface: accepts 18-bit pixel addresses from the background address generator and returns 4-bit palette indices read from the external 16-bit sprite SRAM.
- Each SRAM word packs 4 pixels; a one-word cache serves the 2x-doubled/sequential accesses of scan-out without re-reading SRAM.
- Sits between the background/sprite address logic and the palette lookup feeding VGA colour output.

---
 rtl/bg_sram_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bg_sram_reader.sv
// bg_sram_reader: returns 4-bit palette indices for 18-bit background pixel
//   addresses, reading 16-bit (4-pixel) words from the external sprite SRAM.
//   A one-word cache serves repeated and sequential accesses without an SRAM read.
// Latency: cache hit = 1 cycle, miss = READ_LATENCY+1 cycles from accept to pix_valid.
// Backpressure: req_ready is low while an SRAM read is in flight; req is
//   ignored then (no queue) and must be held by the requester until accepted.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   req, addr, req_ready pixel request handshake (addr sampled on accept)
//   inv                  one-cycle cache invalidate
//   pix_valid, pix_index one-cycle response pulse, index held between pulses
//   sram_*               read-only SRAM port (word address, active-low strobes)

module bg_sram_reader #(
    parameter int          READ_LATENCY = 2,
    parameter logic [19:0] BASE_WORD    = 20'h00000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic [17:0] addr,
    input  logic        inv,
    output logic        req_ready,
    output logic        pix_valid,
    output logic [3:0]  pix_index,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    input  logic [15:0] sram_data_in
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Value of wait_cnt in the final READ cycle, when SRAM data is valid.
    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  wait_cnt;

    logic        cache_valid;
    logic [15:0] cache_tag;
    logic [15:0] cache_word;
    logic [1:0]  nib_q;
    // Set when an invalidate arrives while a fill is outstanding, so the
    // filled word is used for the pending response but not kept as valid.
    logic        fill_inv;

    logic        accept;
    logic        hit;
    logic        miss;
    logic        fill_done;

    function automatic logic [3:0] sel_nibble(input logic [15:0] w, input logic [1:0] s);
        logic [3:0] r;
        case (s)
            2'd0:    r = w[3:0];
            2'd1:    r = w[7:4];
            2'd2:    r = w[11:8];
            default: r = w[15:12];
        endcase
        return r;
    endfunction

    assign accept    = req && req_ready;
    // An invalidate coincident with the request forces a miss.
    assign hit       = cache_valid && (addr[17:2] == cache_tag) && !inv;
    assign miss      = accept && !hit;
    assign fill_done = (state == READ) && (wait_cnt == LAST_WAIT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss)      state_nxt = READ;
            READ:    if (fill_done) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = 1'b1;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        if (state == READ) begin
            req_ready = 1'b0;
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_cnt    <= 3'd0;
            pix_valid   <= 1'b0;
            pix_index   <= 4'd0;
            sram_addr   <= 20'd0;
            cache_valid <= 1'b0;
            cache_tag   <= 16'd0;
            cache_word  <= 16'd0;
            nib_q       <= 2'd0;
            fill_inv    <= 1'b0;
        end else begin
            pix_valid <= 1'b0;

            if (state == READ) begin
                wait_cnt <= fill_done ? 3'd0 : wait_cnt + 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end

            if (state == IDLE) begin
                if (accept && hit) begin
                    pix_valid <= 1'b1;
                    pix_index <= sel_nibble(cache_word, addr[1:0]);
                end
                if (miss) begin
                    // 20-bit add wraps modulo 2^20 by construction.
                    sram_addr <= BASE_WORD + {4'b0000, addr[17:2]};
                    cache_tag <= addr[17:2];
                    nib_q     <= addr[1:0];
                    fill_inv  <= 1'b0;
                end
                // The old word is dropped as soon as a new fill starts.
                if (inv || miss) begin
                    cache_valid <= 1'b0;
                end
            end else begin
                if (inv) begin
                    fill_inv <= 1'b1;
                end
                if (fill_done) begin
                    cache_word  <= sram_data_in;
                    pix_valid   <= 1'b1;
                    pix_index   <= sel_nibble(sram_data_in, nib_q);
                    cache_valid <= !(fill_inv || inv);
                end
            end
        end
    end

endmodule
